// File: rtl/rv32e_alu_issue.sv
// ============================================================================
// rv32e_alu_issue -- RV32E execute-stage issue: decode into a registered ALU
// request (D) and capture the ALU result into a writeback register (W).
// Revision: 1.0
// ============================================================================
`default_nettype none

module rv32e_alu_issue #(
   parameter int RESET_PC_UNUSED = 0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_instr,
   input  logic [31:0] in_pc,
   input  logic [31:0] in_rs1_data,
   input  logic [31:0] in_rs2_data,
   output logic [4:0]  alu_op,
   output logic [31:0] alu_a,
   output logic [31:0] alu_b,
   input  logic [31:0] alu_result,
   output logic        wb_valid,
   input  logic        wb_ready,
   output logic [3:0]  wb_rd,
   output logic        wb_we,
   output logic [31:0] wb_data,
   output logic        wb_branch,
   output logic        wb_taken,
   output logic [31:0] wb_target,
   output logic        wb_illegal
);

   localparam logic [6:0]  c_opc_op     = 7'b0110011;
   localparam logic [6:0]  c_opc_opimm  = 7'b0010011;
   localparam logic [6:0]  c_opc_branch = 7'b1100011;
   localparam logic [6:0]  c_opc_lui    = 7'b0110111;
   localparam logic [6:0]  c_opc_auipc  = 7'b0010111;
   localparam logic [4:0]  c_op_add     = 5'b00000;
   localparam logic [6:0]  c_f7_alt     = 7'b0100000;
   // Reserved parameter; it must stay 0, so it only seeds a zero reset value.
   localparam logic [31:0] c_reset_target = 32'(RESET_PC_UNUSED);

   logic [6:0]  w_opcode, w_f7;
   logic [2:0]  w_f3;
   logic [4:0]  w_rd_f, w_rs1_f, w_rs2_f;
   logic [31:0] w_imm_i, w_imm_b, w_imm_u;

   assign w_opcode = in_instr[6:0];
   assign w_rd_f   = in_instr[11:7];
   assign w_f3     = in_instr[14:12];
   assign w_rs1_f  = in_instr[19:15];
   assign w_rs2_f  = in_instr[24:20];
   assign w_f7     = in_instr[31:25];
   assign w_imm_i  = {{20{in_instr[31]}}, in_instr[31:20]};
   assign w_imm_b  = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                      in_instr[30:25], in_instr[11:8], 1'b0};
   assign w_imm_u  = {in_instr[31:12], 12'b0};

   logic [4:0]  w_op;
   logic [31:0] w_a, w_b, w_target;
   logic [3:0]  w_rd;
   logic        w_we, w_branch, w_illegal;

   always_comb begin
      w_op      = c_op_add;
      w_a       = '0;
      w_b       = '0;
      w_target  = '0;
      w_rd      = w_rd_f[3:0];
      w_we      = 1'b0;
      w_branch  = 1'b0;
      w_illegal = 1'b0;
      case (w_opcode)
         c_opc_op: begin
            w_op = {1'b0, w_f7[5], w_f3};
            w_a  = in_rs1_data;
            w_b  = in_rs2_data;
            w_we = 1'b1;
            if (!((w_f7 == 7'b0) ||
                  (w_f7 == c_f7_alt && (w_f3 == 3'b000 || w_f3 == 3'b101))))
               w_illegal = 1'b1;
            if (w_rd_f[4] || w_rs1_f[4] || w_rs2_f[4])
               w_illegal = 1'b1;
         end
         c_opc_opimm: begin
            w_op = {2'b00, w_f3};
            w_a  = in_rs1_data;
            w_b  = w_imm_i;
            w_we = 1'b1;
            if (w_f3 == 3'b001) begin
               if (w_f7 != 7'b0)
                  w_illegal = 1'b1;
            end else if (w_f3 == 3'b101) begin
               w_b = {27'b0, in_instr[24:20]};
               if (w_f7 == c_f7_alt)
                  w_op = 5'b01101;
               else if (w_f7 != 7'b0)
                  w_illegal = 1'b1;
            end
            if (w_rd_f[4] || w_rs1_f[4])
               w_illegal = 1'b1;
         end
         c_opc_branch: begin
            w_op     = {2'b10, w_f3};
            w_a      = in_rs1_data;
            w_b      = in_rs2_data;
            w_rd     = 4'd0;
            w_branch = 1'b1;
            w_target = in_pc + w_imm_b;
            if (w_f3 == 3'b010 || w_f3 == 3'b011 || w_rs1_f[4] || w_rs2_f[4])
               w_illegal = 1'b1;
         end
         c_opc_lui, c_opc_auipc: begin
            w_a  = (w_opcode == c_opc_auipc) ? in_pc : 32'd0;
            w_b  = w_imm_u;
            w_we = 1'b1;
            if (w_rd_f[4])
               w_illegal = 1'b1;
         end
         default: w_illegal = 1'b1;
      endcase
      // Illegal instructions still flow, but as a harmless ADD 0,0 with no side effects.
      if (w_illegal) begin
         w_op     = c_op_add;
         w_a      = '0;
         w_b      = '0;
         w_rd     = 4'd0;
         w_we     = 1'b0;
         w_branch = 1'b0;
         w_target = '0;
      end else if (w_rd == 4'd0) begin
         w_we = 1'b0;
      end
   end

   logic        r_d_valid, r_d_we, r_d_branch, r_d_illegal;
   logic [3:0]  r_d_rd;
   logic [31:0] r_d_target;
   logic [4:0]  r_alu_op;
   logic [31:0] r_alu_a, r_alu_b;
   logic        r_wb_valid, r_wb_we, r_wb_branch, r_wb_taken, r_wb_illegal;
   logic [3:0]  r_wb_rd;
   logic [31:0] r_wb_data, r_wb_target;
   logic        w_load, w_accept;

   assign w_load   = r_d_valid && (!r_wb_valid || wb_ready);
   assign in_ready = !r_d_valid || w_load;
   assign w_accept = in_valid && in_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_d_valid    <= 1'b0;
         r_alu_op     <= '0;
         r_alu_a      <= '0;
         r_alu_b      <= '0;
         r_d_rd       <= '0;
         r_d_we       <= 1'b0;
         r_d_branch   <= 1'b0;
         r_d_target   <= c_reset_target;
         r_d_illegal  <= 1'b0;
         r_wb_valid   <= 1'b0;
         r_wb_rd      <= '0;
         r_wb_we      <= 1'b0;
         r_wb_data    <= '0;
         r_wb_branch  <= 1'b0;
         r_wb_taken   <= 1'b0;
         r_wb_target  <= c_reset_target;
         r_wb_illegal <= 1'b0;
      end else begin
         if (w_accept) begin
            r_d_valid   <= 1'b1;
            r_alu_op    <= w_op;
            r_alu_a     <= w_a;
            r_alu_b     <= w_b;
            r_d_rd      <= w_rd;
            r_d_we      <= w_we;
            r_d_branch  <= w_branch;
            r_d_target  <= w_target;
            r_d_illegal <= w_illegal;
         end else if (w_load) begin
            r_d_valid <= 1'b0;
         end
         if (w_load) begin
            r_wb_valid   <= 1'b1;
            r_wb_rd      <= r_d_rd;
            r_wb_we      <= r_d_we;
            r_wb_data    <= alu_result;
            r_wb_branch  <= r_d_branch;
            r_wb_taken   <= r_d_branch & alu_result[0];
            r_wb_target  <= r_d_target;
            r_wb_illegal <= r_d_illegal;
         end else if (wb_ready) begin
            r_wb_valid <= 1'b0;
         end
      end
   end

   assign alu_op     = r_alu_op;
   assign alu_a      = r_alu_a;
   assign alu_b      = r_alu_b;
   assign wb_valid   = r_wb_valid;
   assign wb_rd      = r_wb_rd;
   assign wb_we      = r_wb_we;
   assign wb_data    = r_wb_data;
   assign wb_branch  = r_wb_branch;
   assign wb_taken   = r_wb_taken;
   assign wb_target  = r_wb_target;
   assign wb_illegal = r_wb_illegal;

endmodule

`default_nettype wire

// File: doc/rv32e_alu_issue.md
Name: rv32e_alu_issue

Overview:
- Execute-stage initiator for the RV32E ALU: decodes one instruction per handshake into a registered ALU request (op, a, b) and drives it to the ALU.
- Captures the ALU's combinational result in a second register and presents the writeback/branch outcome to the downstream stage over valid/ready.
- Two-entry pipeline (D = request, W = result) with full backpressure and no bubbles at steady state.

Parameters:
- RESET_PC_UNUSED, 0, reserved; must be 0. No configurable widths: XLEN fixed at 32, register index 4 bits (x0..x15).

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  instruction offered
- in_ready  out  1  instruction accepted when in_valid && in_ready
- in_instr  in  32  instruction word
- in_pc  in  32  instruction address
- in_rs1_data  in  32  rs1 operand, already read
- in_rs2_data  in  32  rs2 operand, already read
- alu_op  out  5  registered ALU op code
- alu_a  out  32  registered operand a
- alu_b  out  32  registered operand b
- alu_result  in  32  ALU result (combinational from alu_op/a/b)
- wb_valid  out  1  result available
- wb_ready  in  1  downstream accepts
- wb_rd  out  4  destination register
- wb_we  out  1  register write enable
- wb_data  out  32  write data
- wb_branch  out  1  instruction was a branch
- wb_taken  out  1  branch taken (alu_result[0])
- wb_target  out  32  branch target, pc + B-immediate
- wb_illegal  out  1  decode error

Behaviour:
- Reset (async assert, sync release): d_valid = 0 and wb_valid = 0. All of alu_op, alu_a, alu_b, wb_* data outputs are 0.
- Handshakes:
  - w_load = d_valid && (!wb_valid || wb_ready).
  - in_ready = !d_valid || w_load; purely combinational, with no dependence on in_valid.
  - The D register loads on in_valid && in_ready; d_valid clears on w_load without a new accept.
  - W loads on w_load; wb_valid clears on wb_ready without w_load.
- Latency: accept at edge N gives alu_* valid after N and wb_valid after N+1. Throughput is 1/cycle while wb_ready = 1.
- wb_valid stalled with wb_ready = 0: W holds. D holds (alu_* stable). in_ready = 0 once D is full.
- Decode of in_instr[6:0]:
  - OP 0110011: op = {0, f7[5], f3}, a = rs1, b = rs2. f7 = 0000000 is legal for any f3; f7 = 0100000 is legal only for f3 000/101; all else illegal.
  - OP-IMM 0010011: b = sign-extended I-immediate, a = rs1.
    - f3 001: requires imm[11:5] = 0; op 00001.
    - f3 101: imm[11:5] must be 0000000 (op 00101) or 0100000 (op 01101); b = shamt.
    - Other f3: op = {00, f3}.
  - BRANCH 1100011: op = {10, f3}, a = rs1, b = rs2. f3 010/011 illegal. target = pc + sext({imm[12:1], 0}), mod 2^32.
  - LUI 0110111: op ADD, a = 0, b = {imm[31:12], 12'b0}.
  - AUIPC 0010111: op ADD, a = pc, b = U-immediate.
  - Any other opcode is illegal.
- RV32E: any used rd/rs1/rs2 field with bit 4 = 1 is illegal.
- Illegal instruction: op = ADD, a = b = 0, we = 0, branch = 0, illegal = 1. It still flows through the pipeline; it is never dropped.
- wb_we = 1 for legal OP/OP-IMM/LUI/AUIPC with rd ≠ 0. Branches: we = 0, rd = 0.
- wb_data = alu_result sampled at w_load. wb_taken = alu_result[0] for branches, else 0.
- Simultaneous events:
  - W drain, D→W move and new accept can all occur in the same cycle.
  - Reset mid-operation discards D and W contents with no partial output.

Test Plan:
- Reset with in_valid = 1 → in_ready = 1, wb_valid = 0 and all outputs 0 while rst_n = 0. First accept after release → wb_valid two edges later.
- ADD then SUB (rs1 = 5, rs2 = 7), wb_ready = 1 → alu_op 00000 then 01000; wb_data 12 then 0xFFFFFFFE; wb_valid on consecutive cycles.
- SRAI x3, x1, 4 with rs1 = 0x80000000 → alu_op 01101, alu_b = 4, wb_data 0xF8000000, wb_we = 1, wb_rd = 3.
- BLT, pc = 0x100, offset -8, rs1 = -1, rs2 = 1 → wb_branch = 1, wb_taken = 1, wb_target 0xF8, wb_we = 0.
- Backpressure: wb_ready = 0 for 3 cycles with 3 instructions offered → 2 accepted, in_ready = 0, alu_* stable. Release → in-order delivery with no loss or duplication.
- Illegal cases: ADD x16, opcode 0000000, and OP with f7 = 0100000 & f3 = 001 → each gives wb_illegal = 1, wb_we = 0, wb_data 0, alu_op 00000.
